max_pool: RTL and testbench

1D max-pooling stage with valid/ready handshakes on both sides. It sits directly downstream of the `relu` activation stage and consumes its output stream. It reduces each non-overlapping window of `POOL_SIZE` consecutive samples to its signed maximum, so the stride equals `POOL_SIZE`. The result goes to the next convolution or dense layer.

---
 rtl/max_pool.sv | 76 +++++++
 tb/tb_max_pool.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/max_pool.sv
// rtl/max_pool.sv - 1D signed max-pooling stage with valid/ready handshakes
module max_pool #(
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  max_pool_ready_in,
  input  logic                  max_pool_valid_in,
  input  logic [DATA_WIDTH-1:0] max_pool_data_in,
  input  logic                  max_pool_ready_out,
  output logic                  max_pool_valid_out,
  output logic [DATA_WIDTH-1:0] max_pool_data_out
);

  localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0]             cnt;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [DATA_WIDTH-1:0] running_max;
  logic signed [DATA_WIDTH-1:0] window_max;
  logic [DATA_WIDTH-1:0]        data_reg;
  logic                         valid_reg;
  logic                         is_last;
  logic                         in_xfer;
  logic                         out_xfer;

  assign sample      = $signed(max_pool_data_in);
  assign running_max = (acc > sample) ? acc : sample;
  // A one-sample window has no accumulated history, so the sample itself is the result.
  assign window_max  = (POOL_SIZE == 1) ? sample : running_max;

  assign is_last  = (cnt == LAST);
  assign in_xfer  = max_pool_valid_in & max_pool_ready_in;
  assign out_xfer = valid_reg & max_pool_ready_out;

  // Only the window-closing sample needs the output register free; earlier samples just fold into acc.
  assign max_pool_ready_in  = ~valid_reg | max_pool_ready_out | ~is_last;
  assign max_pool_valid_out = valid_reg;
  assign max_pool_data_out  = data_reg;

  // Window counter and running maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_xfer) begin
      if (is_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == '0) begin
          acc <= sample;
        end else begin
          acc <= running_max;
        end
      end
    end
  end

  // Output register: load on window close (even while draining), clear valid on a bare drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_xfer && is_last) begin
      valid_reg <= 1'b1;
      data_reg  <= window_max;
    end else if (out_xfer) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max_pool.sv
// tb/tb_max_pool.sv - directed self-checking bench for max_pool (pool sizes 2, 3 and 1)
module tb_max_pool;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        ri2, v2, ro2, vo2;
  logic [11:0] d2, do2;
  logic        ri3, v3, ro3, vo3;
  logic [11:0] d3, do3;
  logic        ri1, v1, ro1, vo1;
  logic [11:0] d1, do1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  max_pool #(.DATA_WIDTH(12), .POOL_SIZE(2)) u_p2 (
    .clk(clk), .rst(rst),
    .max_pool_ready_in(ri2), .max_pool_valid_in(v2), .max_pool_data_in(d2),
    .max_pool_ready_out(ro2), .max_pool_valid_out(vo2), .max_pool_data_out(do2)
  );

  max_pool #(.DATA_WIDTH(12), .POOL_SIZE(3)) u_p3 (
    .clk(clk), .rst(rst),
    .max_pool_ready_in(ri3), .max_pool_valid_in(v3), .max_pool_data_in(d3),
    .max_pool_ready_out(ro3), .max_pool_valid_out(vo3), .max_pool_data_out(do3)
  );

  max_pool #(.DATA_WIDTH(12), .POOL_SIZE(1)) u_p1 (
    .clk(clk), .rst(rst),
    .max_pool_ready_in(ri1), .max_pool_valid_in(v1), .max_pool_data_in(d1),
    .max_pool_ready_out(ro1), .max_pool_valid_out(vo1), .max_pool_data_out(do1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL reset_valid2 got %b exp 0", vo2); end
    n_vec++; if (do2 !== 12'h000) begin n_err++; $display("FAIL reset_data2 got %h exp 000", do2); end
    n_vec++; if (ri2 !== 1'b1) begin n_err++; $display("FAIL reset_ready2 got %b exp 1", ri2); end
    n_vec++; if (vo3 !== 1'b0) begin n_err++; $display("FAIL reset_valid3 got %b exp 0", vo3); end
    n_vec++; if (vo1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1 got %b exp 0", vo1); end
  endtask

  task automatic test_stream;
    logic [11:0] din [4] = '{12'd5, 12'd9, 12'd3, 12'd1};
    logic        vexp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] dexp [4] = '{12'd0, 12'd9, 12'd9, 12'd3};
    ro2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v2 = 1'b1;
      d2 = din[i];
      n_vec++; if (ri2 !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, ri2); end
      tick();
      n_vec++; if (vo2 !== vexp[i]) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp %b", i, vo2, vexp[i]); end
      if (vexp[i]) begin
        n_vec++; if (do2 !== dexp[i]) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", i, do2, dexp[i]); end
      end
    end
    v2 = 1'b0;
    tick();
    n_vec++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b exp 0", vo2); end
  endtask

  task automatic test_signed;
    logic [11:0] a [3] = '{12'hFFE, 12'h800, 12'h004};
    logic [11:0] b [3] = '{12'hFFB, 12'h7FF, 12'h004};
    logic [11:0] e [3] = '{12'hFFE, 12'h7FF, 12'h004};
    ro2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v2 = 1'b1;
      d2 = a[i];
      tick();
      d2 = b[i];
      tick();
      n_vec++; if (vo2 !== 1'b1) begin n_err++; $display("FAIL signed_valid[%0d] got %b exp 1", i, vo2); end
      n_vec++; if (do2 !== e[i]) begin n_err++; $display("FAIL signed_data[%0d] got %h exp %h", i, do2, e[i]); end
    end
    v2 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    ro2 = 1'b1;
    v2 = 1'b1; d2 = 12'd5; tick();
    d2 = 12'd9; tick();
    n_vec++; if (do2 !== 12'd9 || vo2 !== 1'b1) begin n_err++; $display("FAIL bp_first got %b/%h exp 1/009", vo2, do2); end
    ro2 = 1'b0;
    d2 = 12'd4;
    #1;
    n_vec++; if (ri2 !== 1'b1) begin n_err++; $display("FAIL bp_nonfinal_ready got %b exp 1", ri2); end
    tick();
    d2 = 12'd6;
    n_vec++; if (ri2 !== 1'b0) begin n_err++; $display("FAIL bp_final_ready got %b exp 0", ri2); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (vo2 !== 1'b1 || do2 !== 12'd9 || ri2 !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h r=%b exp v=1 d=009 r=0", i, vo2, do2, ri2); end
    end
    ro2 = 1'b1;
    #1;
    n_vec++; if (ri2 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", ri2); end
    tick();
    v2 = 1'b0;
    n_vec++; if (vo2 !== 1'b1 || do2 !== 12'd6) begin n_err++; $display("FAIL bp_next got %b/%h exp 1/006", vo2, do2); end
    tick();
    n_vec++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", vo2); end
  endtask

  task automatic test_back_to_back;
    ro2 = 1'b1;
    v2 = 1'b1; d2 = 12'd5; tick();
    d2 = 12'd9; tick();
    ro2 = 1'b0;
    d2 = 12'd1; tick();
    n_vec++; if (vo2 !== 1'b1 || do2 !== 12'd9) begin n_err++; $display("FAIL b2b_pending got %b/%h exp 1/009", vo2, do2); end
    ro2 = 1'b1;
    d2 = 12'd7; tick();
    v2 = 1'b0;
    n_vec++; if (vo2 !== 1'b1 || do2 !== 12'd7) begin n_err++; $display("FAIL b2b_reload got %b/%h exp 1/007", vo2, do2); end
    tick();
    n_vec++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", vo2); end
  endtask

  task automatic test_reset_mid;
    ro2 = 1'b1;
    v2 = 1'b1; d2 = 12'd7; tick();
    v2 = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    v2 = 1'b1; d2 = 12'd2; tick();
    n_vec++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL rstmid_early got %b exp 0", vo2); end
    d2 = 12'd1; tick();
    v2 = 1'b0;
    n_vec++; if (vo2 !== 1'b1 || do2 !== 12'd2) begin n_err++; $display("FAIL rstmid_out got %b/%h exp 1/002", vo2, do2); end
    tick();
    ro2 = 1'b0;
    v2 = 1'b1; d2 = 12'd5; tick();
    d2 = 12'd9; tick();
    v2 = 1'b0;
    n_vec++; if (vo2 !== 1'b1) begin n_err++; $display("FAIL rstpend_setup got %b exp 1", vo2); end
    rst = 1'b1; tick();
    rst = 1'b0;
    n_vec++; if (vo2 !== 1'b0 || do2 !== 12'h000) begin n_err++; $display("FAIL rstpend_clear got %b/%h exp 0/000", vo2, do2); end
    ro2 = 1'b1;
  endtask

  task automatic test_pool3;
    ro3 = 1'b1;
    v3 = 1'b1; d3 = 12'd1; tick();
    d3 = 12'd8; tick();
    v3 = 1'b0; d3 = 12'h7FF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (vo3 !== 1'b0) begin n_err++; $display("FAIL p3_gap[%0d] got %b exp 0", i, vo3); end
    end
    v3 = 1'b1; d3 = 12'd2; tick();
    n_vec++; if (vo3 !== 1'b1 || do3 !== 12'd8) begin n_err++; $display("FAIL p3_first got %b/%h exp 1/008", vo3, do3); end
    d3 = 12'd0; tick();
    n_vec++; if (vo3 !== 1'b0) begin n_err++; $display("FAIL p3_between got %b exp 0", vo3); end
    d3 = 12'd0; tick();
    d3 = 12'd4; tick();
    v3 = 1'b0;
    n_vec++; if (vo3 !== 1'b1 || do3 !== 12'd4) begin n_err++; $display("FAIL p3_second got %b/%h exp 1/004", vo3, do3); end
    tick();
    n_vec++; if (vo3 !== 1'b0) begin n_err++; $display("FAIL p3_drain got %b exp 0", vo3); end
  endtask

  task automatic test_pool1;
    ro1 = 1'b1;
    v1 = 1'b1; d1 = 12'd3; tick();
    n_vec++; if (vo1 !== 1'b1 || do1 !== 12'd3) begin n_err++; $display("FAIL p1_first got %b/%h exp 1/003", vo1, do1); end
    d1 = 12'hFFF; tick();
    v1 = 1'b0;
    n_vec++; if (vo1 !== 1'b1 || do1 !== 12'hFFF) begin n_err++; $display("FAIL p1_second got %b/%h exp 1/fff", vo1, do1); end
    tick();
    n_vec++; if (vo1 !== 1'b0) begin n_err++; $display("FAIL p1_drain got %b exp 0", vo1); end
  endtask

  initial begin
    v2 = 1'b0; d2 = '0; ro2 = 1'b1;
    v3 = 1'b0; d3 = '0; ro3 = 1'b1;
    v1 = 1'b0; d1 = '0; ro1 = 1'b1;
    test_reset();
    test_stream();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_pool3();
    test_pool1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
